xcvr_pattern_gen_hs: RTL
========================

Name: xcvr_pattern_gen_hs

Overview:
Next-generation transceiver test pattern source, parametrised in datapath width. Produces PRBS7/15/23/31, fixed-word, counter and clock-like patterns with a valid/ready output handshake. Adds one-shot error injection, polarity inversion and a coherent 64-bit beat counter. It sits between the CSR interconnect and the TX PHY parallel data input in the xcvr test system.

Parameters:
DATA_W, 128, output data width in bits; multiple of 32, range 32..512.
CNT_W, 64, width of the accepted-beat counter; fixed at 64 for the CSR map.

Ports:
clk_clk  in  1  single clock for CSR and datapath.
reset_reset  in  1  synchronous, active-high reset.
csr_slave_address  in  3  CSR word address.
csr_slave_write  in  1  write strobe.
csr_slave_read  in  1  read strobe.
csr_slave_byteenable  in  4  write byte lanes.
csr_slave_writedata  in  32  write data.
csr_slave_readdata  out  32  read data; registered.
aso_data  out  DATA_W  pattern beat; bit DATA_W-1 is first in time.
aso_valid  out  1  beat valid.
aso_ready  in  1  sink accepts beat.

Behaviour:
- Clocking and reset: one clock, clk_clk. reset_reset is synchronous and active-high.
- Reset values: readdata=0, aso_data=0, aso_valid=0, CTRL=0, FIXED=0, SEED=0x7FFFFFFF, counter=0, inject pending=0.
- CSR map; writes honour byteenable:
  - 0 CTRL: [0] enable, [3:1] mode, [4] inject (write-1, self-clearing), [5] invert.
  - 1 FIXED: 32-bit fixed word.
  - 2 SEED: [30:0].
  - 3 CNT_LO (RO). Reading CNT_LO snapshots the counter's upper 32 bits into a shadow register.
  - 4 CNT_HI (RO). Returns the shadow.
  - 5 STATUS (RO): [0] running, [1] inject pending.
  - 6 PARAM (RO): DATA_W.
  - 7: reads 0.
- Read latency: 1 cycle.
- Modes:
  - 0 PRBS7: x^7+x^6+1.
  - 1 PRBS15: x^15+x^14+1.
  - 2 PRBS23: x^23+x^18+1.
  - 3 PRBS31: x^31+x^28+1.
  - 4 FIXED: FIXED replicated across all 32-bit lanes.
  - 5 COUNTER: 32-bit lane i of beat k = k*(DATA_W/32)+i, wraps modulo 2^32.
  - 6 HF: all 0xAAAAAAAA.
  - 7 LF: all 0xF0F0F0F0.
- PRBS generation: Fibonacci LFSR. new bit = s[N-1]^s[M-1]; shift left; the new bit is output. DATA_W bits are generated per beat, unrolled combinationally. LFSR loaded with SEED[N-1:0]; a zero seed is forced to all-ones.
- State machine IDLE -> LOAD -> RUN:
  - IDLE: aso_valid=0.
  - IDLE->LOAD: enable=1.
  - LOAD (1 cycle): latch mode, seed, invert; compute the first beat.
  - LOAD->RUN: aso_valid=1 on the next cycle.
  - RUN->IDLE: enable=0, takes effect next cycle; aso_valid drops even mid-stall.
  - Writes to mode/seed/invert during RUN are stored and applied at the next LOAD only.
- Handshake:
  - A beat transfers when aso_valid&&aso_ready; the generator then advances exactly one beat.
  - While aso_ready=0, aso_data is held stable.
  - Counter increments per transferred beat and wraps at 2^64.
- Counter and reset: the counter is cleared on reset only, not on enable.
- invert: applies bitwise to the whole beat after pattern generation.
- Error injection:
  - Writing inject=1 sets pending.
  - The next transferred beat has aso_data[0] flipped, and pending clears in that same cycle.
  - Generator state is unaffected; the following beats are clean.
  - A pending inject persists across IDLE.
  - A second inject written while pending is absorbed (no double flip).
- Simultaneous events: a CSR write of enable=0 on the same cycle as a transfer still counts that transfer. Reset mid-stream forces IDLE and all reset values immediately.

Decomposition:
- Package xcvr_pattern_pkg holds: the mode enum (MODE_PRBS7..MODE_LF), CSR address constants, CTRL bit-index constants, and the PRBS tap table (N, M per mode).
- Sub-module xcvr_prbs_step: combinational, parametrised by DATA_W. Inputs: 31-bit state and poly select. Outputs: DATA_W bits and next state.

Test Plan:
- DATA_W=8 (bench override), PRBS7, SEED=0x7F, enable, aso_ready=1 -> first valid beat 0x02; pattern repeats with period 127 bits.
- DATA_W=128, COUNTER, aso_ready held low 5 cycles after the 2nd beat -> aso_data held at 0x00000007_00000006_00000005_00000004; next beat lanes 8..11; CNT_LO=2 at release.
- FIXED=0x12345678, invert=1 -> every lane 0xEDCBA987.
- PRBS31, inject written during a stall -> only the next accepted beat differs from the golden model, at bit 0; STATUS[1] reads 1 before and 0 after.
- Preload the counter near 2^32 via a long run (or force), read CNT_LO then CNT_HI -> coherent 64-bit value even when the counter increments between the two reads.
- Reset asserted in RUN mid-stall -> next cycle aso_valid=0, aso_data=0, CTRL=0; re-enable restarts from SEED.

Source files
------------

// File: rtl/xcvr_pattern_pkg.sv
// Shared types and constants for the transceiver pattern generator.
package xcvr_pattern_pkg;

    typedef enum logic [2:0] {
        MODE_PRBS7   = 3'd0,
        MODE_PRBS15  = 3'd1,
        MODE_PRBS23  = 3'd2,
        MODE_PRBS31  = 3'd3,
        MODE_FIXED   = 3'd4,
        MODE_COUNTER = 3'd5,
        MODE_HF      = 3'd6,
        MODE_LF      = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_FIXED  = 3'd1;
    localparam logic [2:0] ADDR_SEED   = 3'd2;
    localparam logic [2:0] ADDR_CNT_LO = 3'd3;
    localparam logic [2:0] ADDR_CNT_HI = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;
    localparam logic [2:0] ADDR_PARAM  = 3'd6;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_MODE_LSB = 1;
    localparam int unsigned CTRL_INJECT   = 4;
    localparam int unsigned CTRL_INVERT   = 5;

    localparam int unsigned LFSR_W = 31;

    // PRBS tap table indexed by the low two mode bits: new bit = s[N-1] ^ s[M-1]
    localparam int unsigned PRBS_N [4] = '{7, 15, 23, 31};
    localparam int unsigned PRBS_M [4] = '{6, 14, 18, 28};

    localparam logic [31:0] HF_WORD  = 32'hAAAA_AAAA;
    localparam logic [31:0] LF_WORD  = 32'hF0F0_F0F0;
    localparam logic [30:0] SEED_RST = 31'h7FFF_FFFF;

    // Mask of the live LFSR bits for a polynomial select
    function automatic logic [30:0] prbs_mask(input logic [1:0] sel);
        logic [30:0] m;
        case (sel)
            2'd0:    m = 31'h0000_007F;
            2'd1:    m = 31'h0000_7FFF;
            2'd2:    m = 31'h007F_FFFF;
            default: m = 31'h7FFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/xcvr_pattern_gen_hs_prbs_step.sv
// One beat of Fibonacci LFSR output, unrolled over DATA_W bits; first bit lands in the MSB.
module xcvr_prbs_step
    import xcvr_pattern_pkg::*;
#(
    parameter int unsigned DATA_W = 128
) (
    input  logic [30:0]       state,
    input  logic [1:0]        poly_sel,
    output logic [DATA_W-1:0] data_c,
    output logic [30:0]       next_state_c
);

    logic [30:0] s;
    logic [30:0] mask;
    logic        nb;

    // Serial shift unrolled into a combinational cone
    always_comb begin
        mask   = prbs_mask(poly_sel);
        s      = state & mask;
        nb     = 1'b0;
        data_c = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            case (poly_sel)
                2'd0:    nb = s[PRBS_N[0]-1] ^ s[PRBS_M[0]-1];
                2'd1:    nb = s[PRBS_N[1]-1] ^ s[PRBS_M[1]-1];
                2'd2:    nb = s[PRBS_N[2]-1] ^ s[PRBS_M[2]-1];
                default: nb = s[PRBS_N[3]-1] ^ s[PRBS_M[3]-1];
            endcase
            s = {s[29:0], nb} & mask;
            data_c[DATA_W-1-i] = nb;
        end
        next_state_c = s;
    end

endmodule

// File: rtl/xcvr_pattern_gen_hs.sv
// Transceiver test pattern source with CSR slave and valid/ready beat output.
module xcvr_pattern_gen_hs
    import xcvr_pattern_pkg::*;
#(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CNT_W  = 64
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [2:0]        csr_slave_address,
    input  logic              csr_slave_write,
    input  logic              csr_slave_read,
    input  logic [3:0]        csr_slave_byteenable,
    input  logic [31:0]       csr_slave_writedata,
    output logic [31:0]       csr_slave_readdata,
    output logic [DATA_W-1:0] aso_data,
    output logic              aso_valid,
    input  logic              aso_ready
);

    localparam int unsigned LANES = DATA_W / 32;

    // CSR-visible configuration
    logic              ctrl_en_q;
    mode_e             ctrl_mode_q;
    logic              ctrl_inv_q;
    logic [31:0]       fixed_q;
    logic [30:0]       seed_q;
    logic [31:0]       shadow_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              pend_q;

    // Stream state
    state_e            state_q, state_d;
    mode_e             act_mode_q;
    logic              act_inv_q;
    logic [30:0]       lfsr_q;
    logic [31:0]       ctr_base_q;
    logic [DATA_W-1:0] beat_q;

    logic              load_c, adv_c;
    logic              xfer_c, wr_ctrl_c, inject_wr_c, en_d_c;
    logic              pend_d, valid_d;
    mode_e             mode_act;
    logic              inv_act;
    logic [30:0]       seed_m, seed_state, step_in;
    logic [31:0]       ctr_base;
    logic [DATA_W-1:0] prbs_data, pat, gen, beat_d;
    logic [30:0]       prbs_next;
    logic [31:0]       fixed_be, seed_be, rd_mux;

    assign xfer_c      = aso_valid & aso_ready;
    assign wr_ctrl_c   = csr_slave_write && (csr_slave_address == ADDR_CTRL) && csr_slave_byteenable[0];
    assign inject_wr_c = wr_ctrl_c & csr_slave_writedata[CTRL_INJECT];
    assign en_d_c      = wr_ctrl_c ? csr_slave_writedata[CTRL_EN] : ctrl_en_q;

    // FSM state register
    always_ff @(posedge clk_clk) begin
        if (reset_reset) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    // FSM next state; a disable write stops the stream at the same edge it is stored
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        adv_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_en_q) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                load_c  = 1'b1;
                state_d = en_d_c ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                adv_c = xfer_c;
                if (!en_d_c) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Select live vs. freshly loaded configuration and LFSR start state
    always_comb begin
        mode_act   = load_c ? ctrl_mode_q : act_mode_q;
        inv_act    = load_c ? ctrl_inv_q  : act_inv_q;
        seed_m     = seed_q & prbs_mask(mode_act[1:0]);
        seed_state = (seed_m == '0) ? prbs_mask(mode_act[1:0]) : seed_m;
        step_in    = load_c ? seed_state : lfsr_q;
        ctr_base   = load_c ? 32'd0 : ctr_base_q;
    end

    xcvr_prbs_step #(
        .DATA_W (DATA_W)
    ) u_prbs_step (
        .state        (step_in),
        .poly_sel     (mode_act[1:0]),
        .data_c       (prbs_data),
        .next_state_c (prbs_next)
    );

    // Pattern mux, then polarity inversion over the whole beat
    always_comb begin
        pat = '0;
        case (mode_act)
            MODE_PRBS7, MODE_PRBS15, MODE_PRBS23, MODE_PRBS31: pat = prbs_data;
            MODE_FIXED: pat = {LANES{fixed_q}};
            MODE_COUNTER: begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    pat[32*i +: 32] = ctr_base + 32'(i);
                end
            end
            MODE_HF: pat = {LANES{HF_WORD}};
            MODE_LF: pat = {LANES{LF_WORD}};
            default: pat = '0;
        endcase
        gen = pat ^ {DATA_W{inv_act}};
    end

    // Next clean beat, inject bookkeeping and output valid
    always_comb begin
        beat_d  = (load_c | adv_c) ? gen : beat_q;
        valid_d = (state_d == ST_RUN);
        // A write while already pending is absorbed; a transfer consumes the pending flip
        pend_d  = (pend_q & ~xfer_c) | (inject_wr_c & ~pend_q);
    end

    // Datapath registers; aso_data carries the clean beat with bit 0 flipped while an inject is owed
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            act_mode_q <= MODE_PRBS7;
            act_inv_q  <= 1'b0;
            lfsr_q     <= '0;
            ctr_base_q <= '0;
            beat_q     <= '0;
            aso_data   <= '0;
            aso_valid  <= 1'b0;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (load_c) begin
                act_mode_q <= ctrl_mode_q;
                act_inv_q  <= ctrl_inv_q;
            end
            if (load_c | adv_c) lfsr_q <= prbs_next;
            if (load_c)         ctr_base_q <= 32'(LANES);
            else if (adv_c)     ctr_base_q <= ctr_base_q + 32'(LANES);
            beat_q    <= beat_d;
            aso_data  <= beat_d ^ DATA_W'(pend_d & valid_d);
            aso_valid <= valid_d;
            pend_q    <= pend_d;
            if (xfer_c) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Byte-lane merge for FIXED and SEED writes
    always_comb begin
        fixed_be = fixed_q;
        seed_be  = {1'b0, seed_q};
        for (int unsigned b = 0; b < 4; b++) begin
            if (csr_slave_byteenable[b]) begin
                fixed_be[8*b +: 8] = csr_slave_writedata[8*b +: 8];
                seed_be[8*b +: 8]  = csr_slave_writedata[8*b +: 8];
            end
        end
    end

    // CSR write registers
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            ctrl_en_q   <= 1'b0;
            ctrl_mode_q <= MODE_PRBS7;
            ctrl_inv_q  <= 1'b0;
            fixed_q     <= '0;
            seed_q      <= SEED_RST;
        end else if (csr_slave_write) begin
            if (wr_ctrl_c) begin
                ctrl_en_q   <= csr_slave_writedata[CTRL_EN];
                ctrl_mode_q <= mode_e'(csr_slave_writedata[CTRL_MODE_LSB +: 3]);
                ctrl_inv_q  <= csr_slave_writedata[CTRL_INVERT];
            end
            if (csr_slave_address == ADDR_FIXED) fixed_q <= fixed_be;
            if (csr_slave_address == ADDR_SEED)  seed_q  <= seed_be[30:0];
        end
    end

    // Read mux; inject reads back as 0 since it is a strobe
    always_comb begin
        case (csr_slave_address)
            ADDR_CTRL:   rd_mux = {26'd0, ctrl_inv_q, 1'b0, ctrl_mode_q, ctrl_en_q};
            ADDR_FIXED:  rd_mux = fixed_q;
            ADDR_SEED:   rd_mux = {1'b0, seed_q};
            ADDR_CNT_LO: rd_mux = cnt_q[31:0];
            ADDR_CNT_HI: rd_mux = shadow_q;
            ADDR_STATUS: rd_mux = {30'd0, pend_q, (state_q != ST_IDLE)};
            ADDR_PARAM:  rd_mux = 32'(DATA_W);
            default:     rd_mux = 32'd0;
        endcase
    end

    // Registered read data; a CNT_LO read freezes the upper half for a coherent CNT_HI read
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            csr_slave_readdata <= '0;
            shadow_q           <= '0;
        end else begin
            csr_slave_readdata <= csr_slave_read ? rd_mux : 32'd0;
            if (csr_slave_read && (csr_slave_address == ADDR_CNT_LO)) shadow_q <= cnt_q[63:32];
        end
    end

endmodule
